// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg -- shared definitions for the MEM-stage load/store unit.
//
// Holds the control-word bit positions decoded by the LSU, the access-size
// encodings, the two-state FSM enum and two small address helpers used by
// both the top level and the alignment sub-module.
// ============================================================================
package lsu_pkg;

    localparam int CW_W             = 35;
    localparam int CW_MEM_READ      = 0;
    localparam int CW_MEM_WRITE     = 1;
    localparam int CW_SIZE_LSB      = 2;
    localparam int CW_SIZE_MSB      = 3;
    localparam int CW_LOAD_UNSIGNED = 4;

    // Size field encodings; 2'b11 is treated as a word access.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } lsu_state_e;

    // Byte lane the access starts on, with the low address bits forced to the
    // natural alignment of the access size.
    function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: lane_offset = addr_lo;
            SIZE_HALF: lane_offset = {addr_lo[1], 1'b0};
            default:   lane_offset = 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align -- combinational byte-lane steering for the LSU.
//
// Ports:
//   size_i          access size (byte/half/word)
//   offset_i        low two address bits of the access
//   load_unsigned_i zero-extend instead of sign-extend loads
//   store_data_i    store data (Rs2)
//   rdata_i         raw word returned by data memory
//   be_o            byte enables for the data bus
//   wdata_o         store data replicated across all byte lanes
//   load_data_o     loaded value shifted down and extended to 32 bits
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        off         = lane_offset(size_i, offset_i);
        shifted     = rdata_i >> {off, 3'b000};
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = shifted;
        case (size_i)
            SIZE_BYTE: begin
                be_o        = 4'b0001 << off;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = load_unsigned_i ? {24'h0, shifted[7:0]}
                                              : 32'($signed(shifted[7:0]));
            end
            SIZE_HALF: begin
                be_o        = 4'b0011 << off;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = load_unsigned_i ? {16'h0, shifted[15:0]}
                                              : 32'($signed(shifted[15:0]));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu -- MEM pipeline stage with a ready/valid-style data bus.
//
// Non-memory ops pass straight through to MEM/WB with one cycle of latency.
// A memory op is captured, the pipeline is stalled, and the request is held
// on the bus until dmem_ready; the completed op (with its load data) is then
// written to the MEM/WB outputs. An optional timeout turns a hung access into
// a bus error.
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles before a bus error (0 = never)
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   control_word_in, PC_in,
//   immediate_in, Rs2_in,
//   FU_result_in                     EXE/MEM register contents
//   stall_o                          hold EXE/MEM and upstream stages
//   dmem_req/we/addr/wdata/be        data-memory request
//   dmem_ready, dmem_rdata           data-memory response
//   control_word_out, PC_out,
//   FU_result_out, mem_data_out,
//   misalign_out, bus_err_out        registered MEM/WB outputs
// Configuration:
//   LSU_MISALIGN_TRAP_EN  misaligned half/word ops skip the bus and pass
//                         through with misalign_out=1; otherwise the low
//                         address bits are forced to alignment.
// ============================================================================
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW_W-1:0]  control_word_in,
    input  logic [31:0]      PC_in,
    input  logic [31:0]      immediate_in,
    input  logic [31:0]      Rs2_in,
    input  logic [31:0]      FU_result_in,
    output logic             stall_o,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic [CW_W-1:0]  control_word_out,
    output logic [31:0]      PC_out,
    output logic [31:0]      FU_result_out,
    output logic [31:0]      mem_data_out,
    output logic             misalign_out,
    output logic             bus_err_out
);

    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    lsu_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [CW_W-1:0] cw_cap_q, cw_cap_d;
    logic [31:0]     pc_cap_q, pc_cap_d;
    logic [31:0]     addr_cap_q, addr_cap_d;
    logic [31:0]     rs2_cap_q, rs2_cap_d;

    logic [CW_W-1:0] cw_out_d;
    logic [31:0]     pc_out_d, fu_out_d, mdata_out_d;
    logic            mis_out_d, berr_out_d;

    logic            mem_op_in, misalign_in, start_access, timeout_hit, stall;
    logic            cap_is_load;
    logic [3:0]      be_a;
    logic [31:0]     wdata_a, load_a;

    // The immediate is carried by EXE/MEM but has no role in this stage.
    logic            unused_imm;
    assign unused_imm = ^immediate_in;

    assign mem_op_in = control_word_in[CW_MEM_READ] | control_word_in[CW_MEM_WRITE];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_in = mem_op_in &&
        is_misaligned(control_word_in[CW_SIZE_MSB:CW_SIZE_LSB], FU_result_in[1:0]);
`else
    assign misalign_in = 1'b0;
`endif

    assign start_access = (state_q == S_IDLE) && mem_op_in && !misalign_in;
    assign timeout_hit  = (TIMEOUT_CYCLES > 0) && (state_q == S_ACCESS) && (cnt_q == TMO_LAST);
    // A store wins when both read and write are set.
    assign cap_is_load  = cw_cap_q[CW_MEM_READ] & ~cw_cap_q[CW_MEM_WRITE];

    lsu_align u_align (
        .size_i          (cw_cap_q[CW_SIZE_MSB:CW_SIZE_LSB]),
        .offset_i        (addr_cap_q[1:0]),
        .load_unsigned_i (cw_cap_q[CW_LOAD_UNSIGNED]),
        .store_data_i    (rs2_cap_q),
        .rdata_i         (dmem_rdata),
        .be_o            (be_a),
        .wdata_o         (wdata_a),
        .load_data_o     (load_a)
    );

    // Bus fields come from the captured op, so they are stable for the whole
    // access; they are zeroed whenever no request is outstanding.
    assign dmem_req   = req_q;
    assign dmem_we    = req_q & cw_cap_q[CW_MEM_WRITE];
    assign dmem_addr  = req_q ? {addr_cap_q[31:2], 2'b00} : 32'h0;
    assign dmem_wdata = req_q ? wdata_a : 32'h0;
    assign dmem_be    = req_q ? be_a : 4'h0;
    assign stall_o    = rst & stall;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        cw_cap_d    = cw_cap_q;
        pc_cap_d    = pc_cap_q;
        addr_cap_d  = addr_cap_q;
        rs2_cap_d   = rs2_cap_q;
        cw_out_d    = '0;
        pc_out_d    = '0;
        fu_out_d    = '0;
        mdata_out_d = '0;
        mis_out_d   = 1'b0;
        berr_out_d  = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_access) begin
                    // Capture the op and send a bubble down to MEM/WB.
                    state_d    = S_ACCESS;
                    req_d      = 1'b1;
                    cnt_d      = '0;
                    cw_cap_d   = control_word_in;
                    pc_cap_d   = PC_in;
                    addr_cap_d = FU_result_in;
                    rs2_cap_d  = Rs2_in;
                    stall      = 1'b1;
                end else begin
                    cw_out_d  = control_word_in;
                    pc_out_d  = PC_in;
                    fu_out_d  = FU_result_in;
                    mis_out_d = misalign_in;
                end
            end
            S_ACCESS: begin
                if (dmem_ready || timeout_hit) begin
                    // Ready takes priority over a timeout in the same cycle.
                    state_d     = S_IDLE;
                    req_d       = 1'b0;
                    cw_out_d    = cw_cap_q;
                    pc_out_d    = pc_cap_q;
                    fu_out_d    = addr_cap_q;
                    mdata_out_d = (dmem_ready && cap_is_load) ? load_a : 32'h0;
                    berr_out_d  = !dmem_ready;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            req_q            <= 1'b0;
            cnt_q            <= '0;
            cw_cap_q         <= '0;
            pc_cap_q         <= '0;
            addr_cap_q       <= '0;
            rs2_cap_q        <= '0;
            control_word_out <= '0;
            PC_out           <= '0;
            FU_result_out    <= '0;
            mem_data_out     <= '0;
            misalign_out     <= 1'b0;
            bus_err_out      <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            cnt_q            <= cnt_d;
            cw_cap_q         <= cw_cap_d;
            pc_cap_q         <= pc_cap_d;
            addr_cap_q       <= addr_cap_d;
            rs2_cap_q        <= rs2_cap_d;
            control_word_out <= cw_out_d;
            PC_out           <= pc_out_d;
            FU_result_out    <= fu_out_d;
            mem_data_out     <= mdata_out_d;
            misalign_out     <= mis_out_d;
            bus_err_out      <= berr_out_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// tb_mem_stage_lsu -- self-checking bench for mem_stage_lsu (TIMEOUT_CYCLES=4).
// A transaction-level model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
// ============================================================================
module tb_mem_stage_lsu;

    localparam int TB_TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [34:0] control_word_in = '0;
    logic [31:0] PC_in = '0, immediate_in = '0, Rs2_in = '0, FU_result_in = '0;
    logic        stall_o, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [34:0] control_word_out;
    logic [31:0] PC_out, FU_result_out, mem_data_out;
    logic        misalign_out, bus_err_out;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk), .rst(rst),
        .control_word_in(control_word_in), .PC_in(PC_in), .immediate_in(immediate_in),
        .Rs2_in(Rs2_in), .FU_result_in(FU_result_in),
        .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .control_word_out(control_word_out), .PC_out(PC_out), .FU_result_out(FU_result_out),
        .mem_data_out(mem_data_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [34:0] cw);
        return (cw[3:2] == 2'b00) ? 1 : (cw[3:2] == 2'b01) ? 2 : 4;
    endfunction
    function automatic int eff_off(input logic [34:0] cw, input logic [31:0] a);
        int n = nbytes(cw);
        return (int'(a % 4) / n) * n;
    endfunction
    function automatic bit is_mem(input logic [34:0] cw);
        return cw[0] || cw[1];
    endfunction
    function automatic bit is_load(input logic [34:0] cw);
        return cw[0] && !cw[1];
    endfunction
    function automatic bit trap_mis(input logic [34:0] cw, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return is_mem(cw) && ((int'(a % 4) % nbytes(cw)) != 0);
`else
        return 1'b0;
`endif
    endfunction
    function automatic logic [3:0] m_be_of(input logic [34:0] cw, input logic [31:0] a);
        logic [7:0] m = 8'((1 << nbytes(cw)) - 1);
        return 4'(m << eff_off(cw, a));
    endfunction
    function automatic logic [31:0] m_wdata_of(input logic [34:0] cw, input logic [31:0] d);
        case (nbytes(cw))
            1: return {24'h0, d[7:0]} * 32'h01010101;
            2: return {16'h0, d[15:0]} * 32'h00010001;
            default: return d;
        endcase
    endfunction
    function automatic logic [31:0] m_load_of(input logic [34:0] cw, input logic [31:0] a,
                                              input logic [31:0] rd);
        int          n = nbytes(cw);
        logic [31:0] mask, v;
        v = rd >> (8 * eff_off(cw, a));
        if (n == 4) return v;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if (!cw[4] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    bit          m_busy = 1'b0;
    int          m_waits = 0;
    logic [34:0] m_cw = '0, e_cw = '0;
    logic [31:0] m_pc = '0, m_addr = '0, m_rs2 = '0;
    logic [31:0] e_pc = '0, e_fu = '0, e_md = '0;
    logic        e_mis = 1'b0, e_berr = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0; m_waits <= 0; m_cw <= '0; m_pc <= '0; m_addr <= '0; m_rs2 <= '0;
            e_cw <= '0; e_pc <= '0; e_fu <= '0; e_md <= '0; e_mis <= 1'b0; e_berr <= 1'b0;
        end else if (!m_busy) begin
            e_md <= '0; e_berr <= 1'b0;
            if (is_mem(control_word_in) && !trap_mis(control_word_in, FU_result_in)) begin
                m_busy <= 1'b1; m_waits <= 0;
                m_cw <= control_word_in; m_pc <= PC_in; m_addr <= FU_result_in; m_rs2 <= Rs2_in;
                e_cw <= '0; e_pc <= '0; e_fu <= '0; e_mis <= 1'b0;
            end else begin
                e_cw <= control_word_in; e_pc <= PC_in; e_fu <= FU_result_in;
                e_mis <= trap_mis(control_word_in, FU_result_in);
            end
        end else if (dmem_ready || (m_waits + 1 == TB_TMO)) begin
            m_busy <= 1'b0;
            e_cw <= m_cw; e_pc <= m_pc; e_fu <= m_addr; e_mis <= 1'b0;
            e_md <= (dmem_ready && is_load(m_cw)) ? m_load_of(m_cw, m_addr, dmem_rdata) : 32'h0;
            e_berr <= !dmem_ready;
        end else begin
            m_waits <= m_waits + 1;
            e_cw <= '0; e_pc <= '0; e_fu <= '0; e_md <= '0; e_mis <= 1'b0; e_berr <= 1'b0;
        end
    end

    function automatic logic exp_stall();
        if (!rst) return 1'b0;
        if (m_busy) return !dmem_ready && (m_waits + 1 != TB_TMO);
        return is_mem(control_word_in) && !trap_mis(control_word_in, FU_result_in);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_o", stall_o, exp_stall());
            chk("dmem_req", dmem_req, m_busy);
            chk("dmem_we", dmem_we, m_busy && m_cw[1]);
            chk("dmem_addr", dmem_addr, m_busy ? {m_addr[31:2], 2'b00} : 32'h0);
            chk("dmem_be", dmem_be, m_busy ? m_be_of(m_cw, m_addr) : 4'h0);
            chk("dmem_wdata", dmem_wdata, m_busy ? m_wdata_of(m_cw, m_rs2) : 32'h0);
            chk("control_word_out", control_word_out, e_cw);
            chk("PC_out", PC_out, e_pc);
            chk("FU_result_out", FU_result_out, e_fu);
            chk("mem_data_out", mem_data_out, e_md);
            chk("misalign_out", misalign_out, e_mis);
            chk("bus_err_out", bus_err_out, e_berr);
        end
    end

    // ---------------- stimulus ----------------
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [34:0] cw, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] rs2);
        control_word_in = cw; PC_in = pc; FU_result_in = addr; Rs2_in = rs2;
        immediate_in = pc ^ 32'h5555AAAA;
    endtask

    // Presents one op and follows it until the stage stops stalling.
    // ready_after: wait cycles before dmem_ready (-1 = never).
    task automatic run_op(input logic [34:0] cw, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] rs2, input int ready_after, input logic [31:0] rdata,
                          output int stalls, output int reqs, output logic last_stall);
        bit finished = 1'b0;
        stalls = 0; reqs = 0; last_stall = 1'b1;
        cap_we = 1'b0; cap_be = '0; cap_addr = '0; cap_wdata = '0;
        set_in(cw, pc, addr, rs2);
        for (int c = 0; c < 20; c++) begin
            dmem_ready = (ready_after >= 0) && (c == ready_after + 1);
            dmem_rdata = dmem_ready ? rdata : 32'h5A5A5A5A;
            #2;
            if (stall_o) stalls++;
            if (dmem_req) begin
                reqs++; last_stall = stall_o;
                cap_we = dmem_we; cap_be = dmem_be; cap_addr = dmem_addr; cap_wdata = dmem_wdata;
            end
            finished = !stall_o;
            tick();
            if (finished) break;
        end
        chk("op_completes", finished, 1'b1);
        set_in('0, 32'h0, 32'h0, 32'h0);
        dmem_ready = 1'b0;
    endtask

    int   st, rq;
    logic ls;

    initial begin
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_cw_out", control_word_out, 35'h0);
        chk("rst_mdata", mem_data_out, 32'h0);
        chk("rst_berr", bus_err_out, 1'b0);
        rst = 1'b1;

        // Non-memory op passes through; ready/rdata in IDLE are ignored.
        set_in(35'h0A0, 32'h40, 32'h1234, 32'h0);
        dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem_ready = 1'b0;
        chk("nop_cw", control_word_out, 35'h0A0);
        chk("nop_pc", PC_out, 32'h40);
        chk("nop_fu", FU_result_out, 32'h1234);
        chk("nop_mdata", mem_data_out, 32'h0);
        set_in('0, 32'h0, 32'h0, 32'h0);
        tick();

        // Word load, zero waits.
        run_op(35'h009, 32'h80, 32'h100, 32'h0, 0, 32'hDEADBEEF, st, rq, ls);
        chk("wload_stalls", st, 1);
        chk("wload_reqs", rq, 1);
        chk("wload_addr", cap_addr, 32'h100);
        chk("wload_be", cap_be, 4'hF);
        chk("wload_data", mem_data_out, 32'hDEADBEEF);
        chk("wload_pc", PC_out, 32'h80);

        // Signed / unsigned byte load from the top lane.
        run_op(35'h001, 32'h84, 32'h103, 32'h0, 0, 32'h80112233, st, rq, ls);
        chk("sbyte_be", cap_be, 4'b1000);
        chk("sbyte_data", mem_data_out, 32'hFFFFFF80);
        run_op(35'h011, 32'h88, 32'h103, 32'h0, 1, 32'h80112233, st, rq, ls);
        chk("ubyte_data", mem_data_out, 32'h00000080);
        chk("ubyte_stalls", st, 2);

        // Signed half load from the upper half.
        run_op(35'h005, 32'h8C, 32'h102, 32'h0, 0, 32'h80010000, st, rq, ls);
        chk("shalf_be", cap_be, 4'b1100);
        chk("shalf_data", mem_data_out, 32'hFFFF8001);

        // Half store.
        run_op(35'h006, 32'h90, 32'h102, 32'h0000ABCD, 0, 32'h0, st, rq, ls);
        chk("hstore_we", cap_we, 1'b1);
        chk("hstore_be", cap_be, 4'b1100);
        chk("hstore_wdata", cap_wdata, 32'hABCDABCD);
        chk("hstore_addr", cap_addr, 32'h100);
        chk("hstore_mdata", mem_data_out, 32'h0);

        // Read and write both set behaves as a store.
        run_op(35'h00B, 32'h94, 32'h104, 32'h12345678, 0, 32'hCAFEF00D, st, rq, ls);
        chk("rw_we", cap_we, 1'b1);
        chk("rw_mdata", mem_data_out, 32'h0);

        // Wait states.
        run_op(35'h009, 32'h98, 32'h10C, 32'h0, 2, 32'h0BADF00D, st, rq, ls);
        chk("wait_stalls", st, 3);
        chk("wait_reqs", rq, 3);
        chk("wait_data", mem_data_out, 32'h0BADF00D);

        // Timeout: ready never arrives.
        run_op(35'h009, 32'h9C, 32'h200, 32'h0, -1, 32'h0, st, rq, ls);
        chk("tmo_reqs", rq, TB_TMO);
        chk("tmo_last_stall", ls, 1'b0);
        chk("tmo_berr", bus_err_out, 1'b1);
        chk("tmo_mdata", mem_data_out, 32'h0);
        chk("tmo_req_after", dmem_req, 1'b0);

        // Ready in the same cycle the timeout would expire.
        run_op(35'h009, 32'hA0, 32'h204, 32'h0, TB_TMO - 1, 32'h13579BDF, st, rq, ls);
        chk("race_berr", bus_err_out, 1'b0);
        chk("race_data", mem_data_out, 32'h13579BDF);

        // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
        run_op(35'h009, 32'hA4, 32'h101, 32'h0, 0, 32'h11223344, st, rq, ls);
        chk("mis_reqs", rq, 0);
        chk("mis_stalls", st, 0);
        chk("mis_flag", misalign_out, 1'b1);
        chk("mis_mdata", mem_data_out, 32'h0);
`else
        run_op(35'h009, 32'hA4, 32'h101, 32'h0, 0, 32'h11223344, st, rq, ls);
        chk("align_be", cap_be, 4'hF);
        chk("align_data", mem_data_out, 32'h11223344);
        chk("align_flag", misalign_out, 1'b0);
`endif

        // Reset during the second ACCESS cycle.
        set_in(35'h009, 32'hA8, 32'h300, 32'h0);
        dmem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        set_in('0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("rstmid_req", dmem_req, 1'b0);
        chk("rstmid_cw", control_word_out, 35'h0);
        chk("rstmid_pc", PC_out, 32'h0);
        chk("rstmid_berr", bus_err_out, 1'b0);
        rst = 1'b1;
        tick();
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
